// File: rtl/sign_extend_9x16.sv
// Widens an IN_W-bit immediate to OUT_W bits by sign- or zero-extension, with a
// combinational result and a one-cycle registered copy. SE9X16_STATUS_EN adds neg_q/zero_q.
module sign_extend_9x16 #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             zext,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
`ifdef SE9X16_STATUS_EN
  output logic             neg_q,
  output logic             zero_q,
`endif
  output logic             out_valid
);

  logic [OUT_W-1:0] w_out;
  logic [OUT_W-1:0] r_out_q;
  logic             r_valid;

  generate
    if (IN_W < 2 || OUT_W < IN_W) begin : g_bad_params
      $error("sign_extend_9x16: illegal IN_W/OUT_W combination");
    end

    if (OUT_W > IN_W) begin : g_ext
      logic [OUT_W-IN_W-1:0] w_fill;
      assign w_fill = zext ? '0 : {(OUT_W-IN_W){in[IN_W-1]}};
      assign w_out  = {w_fill, in};
    end else begin : g_pass
      // Equal widths leave no extension bits, so zext is intentionally ignored.
      logic w_zext_unused;
      assign w_zext_unused = zext;
      assign w_out         = in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out_q <= w_out;
      end
    end
  end

`ifdef SE9X16_STATUS_EN
  logic r_neg_q;
  logic r_zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q  <= 1'b0;
      r_zero_q <= 1'b0;
    end else if (in_valid) begin
      r_neg_q  <= w_out[OUT_W-1];
      r_zero_q <= (w_out == '0);
    end
  end

  assign neg_q  = r_neg_q;
  assign zero_q = r_zero_q;
`endif

  assign out       = w_out;
  assign out_q     = r_out_q;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_sign_extend_9x16.sv
// Directed self-checking bench for sign_extend_9x16 (status outputs checked when
// SE9X16_STATUS_EN is defined).
module tb_sign_extend_9x16;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [8:0]  in;
  logic        zext;
  logic        in_valid;
  logic [15:0] out;
  logic [15:0] out_q;
  logic        out_valid;
`ifdef SE9X16_STATUS_EN
  logic        neg_q;
  logic        zero_q;
`endif

  int unsigned checks;
  int unsigned errors;

  sign_extend_9x16 #(.IN_W(9), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .zext      (zext),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
`ifdef SE9X16_STATUS_EN
    .neg_q     (neg_q),
    .zero_q    (zero_q),
`endif
    .out_valid (out_valid)
  );

  // Clock can be paused so combinational checks see no edges at all.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0]  vec_in  [5];
  logic [15:0] vec_exp [5];

  initial begin
    checks   = 0;
    errors   = 0;
    clk_en   = 1'b1;
    rst      = 1'b1;
    in       = 9'h000;
    zext     = 1'b0;
    in_valid = 1'b0;

    tick();
    tick();
    chk("reset_out_q", out_q, 16'h0000);
    chk("reset_out_valid", {15'd0, out_valid}, 16'h0001 & 16'h0000);
    rst = 1'b0;

    // Basic sign-extension, combinational then registered.
    zext = 1'b0; in = 9'h166; in_valid = 1'b1;
    #1;
    chk("comb_166", out, 16'hFF66);
    tick();
    chk("reg_166", out_q, 16'hFF66);
    chk("reg_166_valid", {15'd0, out_valid}, 16'h0001);

    // Drop in_valid: register holds, comb path follows input immediately.
    in_valid = 1'b0; in = 9'h005;
    #1;
    chk("comb_005", out, 16'h0005);
    tick();
    chk("hold_out_q", out_q, 16'hFF66);
    chk("hold_valid_low", {15'd0, out_valid}, 16'h0000);
    tick();
    chk("hold_out_q_2", out_q, 16'hFF66);

    // Combinational sweep with the clock stopped.
    clk_en = 1'b0;
    vec_in[0] = 9'h05E; vec_exp[0] = 16'h005E;
    vec_in[1] = 9'h0FF; vec_exp[1] = 16'h00FF;
    vec_in[2] = 9'h1FF; vec_exp[2] = 16'hFFFF;
    vec_in[3] = 9'h101; vec_exp[3] = 16'hFF01;
    vec_in[4] = 9'h100; vec_exp[4] = 16'hFF00;
    for (int i = 0; i < 5; i++) begin
      in = vec_in[i];
      #5;
      chk($sformatf("sext_sweep_%0d", i), out, vec_exp[i]);
    end
    in = 9'h000;
    #5;
    chk("sext_zero", out, 16'h0000);
    zext = 1'b1; in = 9'h1FF;
    #5;
    chk("zext_1FF", out, 16'h01FF);
    in = 9'h100;
    #5;
    chk("zext_100", out, 16'h0100);
    chk("out_q_no_clock", out_q, 16'hFF66);
    clk_en = 1'b1;

    // Reset has priority over in_valid, then capture resumes on the next edge.
    zext = 1'b0; in = 9'h1FF; in_valid = 1'b1; rst = 1'b1;
    tick();
    chk("rst1_out_q", out_q, 16'h0000);
    chk("rst1_valid", {15'd0, out_valid}, 16'h0000);
    tick();
    chk("rst2_out_q", out_q, 16'h0000);
    chk("rst2_valid", {15'd0, out_valid}, 16'h0000);
    chk("rst_comb_tracks", out, 16'hFFFF);
    rst = 1'b0;
    tick();
    chk("post_rst_out_q", out_q, 16'hFFFF);
    chk("post_rst_valid", {15'd0, out_valid}, 16'h0001);

    // Registered zero-extension.
    zext = 1'b1; in = 9'h1FF;
    tick();
    chk("reg_zext_1FF", out_q, 16'h01FF);
    chk("reg_zext_valid", {15'd0, out_valid}, 16'h0001);

`ifdef SE9X16_STATUS_EN
    zext = 1'b0; in = 9'h100;
    tick();
    chk("stat_100_out_q", out_q, 16'hFF00);
    chk("stat_100_neg", {15'd0, neg_q}, 16'h0001);
    chk("stat_100_zero", {15'd0, zero_q}, 16'h0000);
    in = 9'h000;
    tick();
    chk("stat_0_neg", {15'd0, neg_q}, 16'h0000);
    chk("stat_0_zero", {15'd0, zero_q}, 16'h0001);
    in_valid = 1'b0; in = 9'h1FF;
    tick();
    chk("stat_hold_neg", {15'd0, neg_q}, 16'h0000);
    chk("stat_hold_zero", {15'd0, zero_q}, 16'h0001);
    rst = 1'b1;
    tick();
    chk("stat_rst_zero", {15'd0, zero_q}, 16'h0000);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_extend_9x16.md
Name: sign_extend_9x16

Overview:
- Sign-extension unit that widens a 9-bit two's-complement immediate to a 16-bit datapath word.
- Sits between instruction-field decode and the ALU operand mux.
- Provides a zero-latency combinational result and a one-cycle registered copy with a valid flag for pipelined consumers.
- A mode input optionally selects zero-extension instead of sign-extension.

Parameters:
- IN_W, 9, input field width; legal range 2..OUT_W.
- OUT_W, 16, output word width; must satisfy OUT_W >= IN_W.

Ports:
- clk  input  1  single clock; rising edge active.
- rst  input  1  synchronous, active-high reset.
- in  input  IN_W  immediate field to extend.
- zext  input  1  0 = sign-extend, 1 = zero-extend.
- in_valid  input  1  qualifies `in`/`zext` for the registered path.
- out  output  OUT_W  combinational extended value.
- out_q  output  OUT_W  registered extended value.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Combinational path, no clock involvement:
  - out[IN_W-1:0] = in.
  - out[OUT_W-1:IN_W] = all copies of in[IN_W-1] when zext=0; all zeros when zext=1.
  - Result is valid within the same delta cycle as any change on `in` or `zext`.
  - No dependence on clk, rst or in_valid.
- Registered path, 1-cycle latency:
  - On a rising clk with rst=1: out_q <= 0, out_valid <= 0.
  - Otherwise, when in_valid=1: out_q <= combinational out, out_valid <= 1.
  - Otherwise, when in_valid=0: out_q holds its previous value, out_valid <= 0.
- Reset values: out_q = 0, out_valid = 0. `out` is not reset; it always tracks `in`.
- Reset asserted mid-stream:
  - The pending capture is discarded; the next edge with rst=0 and in_valid=1 captures normally.
  - rst has priority over in_valid on the same edge.
- Boundary cases:
  - in = 0x100 (most negative) -> 0xFF00.
  - in = 0x0FF (most positive) -> 0x00FF.
  - in = 0x1FF (-1) -> 0xFFFF.
  - in = 0 -> 0.
  - zext=1 with in = 0x1FF -> 0x01FF.
- If OUT_W == IN_W, out = in; there are no extension bits and zext has no effect.
- Purely arithmetic: no overflow is possible, no state machine, no backpressure. in_valid is accepted every cycle.

Optional Feature:
- Macro: SE9X16_STATUS_EN.
- When defined, two extra registered outputs are added, both updated under the same rules as out_q:
  - neg_q (1 bit) = MSB of the captured out.
  - zero_q (1 bit) = 1 when the captured out == 0.
  - Both reset to 0 and hold when in_valid=0.
- When undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- zext=0, in=0x166 -> out=0xFF66 after settle; with in_valid=1, after one clk out_q=0xFF66 and out_valid=1.
- zext=0, apply in=0x05E, 0x0FF, 0x1FF, 0x101, 0x100 in turn -> out = 0x005E, 0x00FF, 0xFFFF, 0xFF01, 0xFF00, each checked 5 time units after the change with no clock edge.
- zext=1, in=0x1FF -> out=0x01FF; zext=1, in=0x100 -> out=0x0100.
- rst=1 for 2 cycles while in_valid=1, in=0x1FF -> out_q=0, out_valid=0; first edge after rst=0 -> out_q=0xFFFF, out_valid=1.
- in_valid pulsed with in=0x166, then in_valid=0 with in=0x005 -> out_q stays 0xFF66, out_valid falls to 0, while out shows 0x0005 immediately.
- SE9X16_STATUS_EN defined:
  - capture in=0x100 -> neg_q=1, zero_q=0.
  - capture in=0 -> neg_q=0, zero_q=1.
